// File: rtl/craft_round_ctrl.sv
// Round sequencer for a CRAFT-style block cipher datapath: accepts a key/tweak
// job, pulses load, steps NUM_ROUNDS rounds with their tweakeys, then holds the result.
//
// state | meaning
// IDLE  | ready for a job; key/tweak latched on acceptance
// LOAD  | one-cycle load pulse, round counter cleared
// RUN   | one round per cycle, tk driven for the current round
// DONE  | result valid, held until out_ready
module craft_round_ctrl #(
   parameter int unsigned NUM_ROUNDS = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] key,
   input  logic [63:0]  tweak,
   output logic         load,
   output logic         round_en,
   output logic [7:0]   rnd,
   output logic [63:0]  tk,
   output logic         last_round,
   output logic         out_valid,
   input  logic         out_ready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [7:0]  LAST = 8'(NUM_ROUNDS - 1);
   // nibble j of this constant is the source nibble index for output nibble j
   localparam logic [63:0] PERM = 64'hCAF5E892B374601D;

   state_t      state, state_nxt;
   logic [7:0]  cnt;
   logic [63:0] k0, k1, t;
   logic [63:0] tq;
   logic        at_last;

   function automatic logic [63:0] q_perm(input logic [63:0] x);
      logic [3:0] p;
      q_perm = '0;
      for (int j = 0; j < 16; j++) begin
         p = PERM[63-4*j -: 4];
         q_perm[63-4*j -: 4] = x[63-4*int'(p) -: 4];
      end
   endfunction

   assign tq      = q_perm(t);
   assign at_last = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         k0  <= '0;
         k1  <= '0;
         t   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  k0 <= key[127:64];
                  k1 <= key[63:0];
                  t  <= tweak;
               end
            end
            LOAD: cnt <= '0;
            RUN:  if (!at_last) cnt <= cnt + 8'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      load       = 1'b0;
      round_en   = 1'b0;
      rnd        = '0;
      tk         = '0;
      last_round = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = LOAD;
         end
         LOAD: begin
            load      = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            round_en   = 1'b1;
            rnd        = cnt;
            last_round = at_last;
            case (cnt[1:0])
               2'd0:    tk = k0 ^ t;
               2'd1:    tk = k1 ^ t;
               2'd2:    tk = k0 ^ tq;
               default: tk = k1 ^ tq;
            endcase
            if (at_last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_craft_round_ctrl.sv
// Self-checking bench for craft_round_ctrl: directed scenarios plus random traffic,
// compared each cycle against a job-timeline reference model.
module tb_craft_round_ctrl;
   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst, in_valid, out_ready;
   logic [127:0] key;
   logic [63:0]  tweak;
   logic         in_ready, load, round_en, last_round, out_valid;
   logic [7:0]   rnd;
   logic [63:0]  tk;

   int vectors = 0;
   int miscompares = 0;

   // model: m_age = cycles since acceptance of the current job, -1 when idle
   int          m_age = -1;
   logic [63:0] m_k0, m_k1, m_t;
   int          perm [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};

   int          rec_off = -1;
   logic [39:0] o_ld, o_re, o_lr, o_ov, o_ir;
   logic [39:0] e_ld, e_re, e_lr, e_ov, e_ir;
   logic [63:0] tk_log [256];

   always #5 clk = ~clk;

   craft_round_ctrl #(.NUM_ROUNDS(N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .key(key), .tweak(tweak), .load(load), .round_en(round_en),
      .rnd(rnd), .tk(tk), .last_round(last_round), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   function automatic logic [63:0] nib_perm(input logic [63:0] x);
      logic [63:0] r;
      r = '0;
      for (int j = 0; j < 16; j++)
         r = (r << 4) | ((x >> (60 - 4*perm[j])) & 64'hF);
      return r;
   endfunction

   function automatic logic [63:0] ref_tk(input int r);
      case (r % 4)
         0:       return m_k0 ^ m_t;
         1:       return m_k1 ^ m_t;
         2:       return m_k0 ^ nib_perm(m_t);
         default: return m_k1 ^ nib_perm(m_t);
      endcase
   endfunction

   function automatic logic [127:0] r128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [63:0] r64();
      return {$urandom(), $urandom()};
   endfunction

   task automatic chk1(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic check_now();
      bit e_re1;
      int e_rnd;
      e_re1 = (m_age >= 2) && (m_age <= N + 1);
      e_rnd = e_re1 ? m_age - 2 : 0;
      chk1("in_ready",   64'(in_ready),   64'(m_age < 0));
      chk1("load",       64'(load),       64'(m_age == 1));
      chk1("round_en",   64'(round_en),   64'(e_re1));
      chk1("rnd",        64'(rnd),        64'(e_rnd));
      chk1("last_round", 64'(last_round), 64'(e_re1 && e_rnd == N - 1));
      chk1("out_valid",  64'(out_valid),  64'(m_age == N + 2));
      chk1("tk",         tk,              e_re1 ? ref_tk(e_rnd) : 64'h0);
   endtask

   task automatic step(input logic v, input logic ordy, input logic r,
                       input logic [127:0] k, input logic [63:0] tw);
      in_valid = v; out_ready = ordy; rst = r; key = k; tweak = tw;
      @(posedge clk);
      if (r) m_age = -1;
      else if (m_age < 0) begin
         if (v) begin
            m_age = 1;
            m_k0 = k[127:64]; m_k1 = k[63:0]; m_t = tw;
         end
      end
      else if (m_age < N + 2) m_age++;
      else if (ordy) m_age = -1;
      #1;
      check_now();
      if (rec_off >= 0 && rec_off < 40) begin
         o_ld[rec_off] = load; o_re[rec_off] = round_en; o_lr[rec_off] = last_round;
         o_ov[rec_off] = out_valid; o_ir[rec_off] = in_ready;
         rec_off++;
      end
      if (round_en === 1'b1) tk_log[rnd] = tk;
   endtask

   task automatic run_to_idle();
      for (int i = 0; i < 200 && m_age >= 0; i++)
         step(1'b0, 1'b1, 1'b0, r128(), r64());
      if (m_age >= 0) begin
         vectors++; miscompares++;
         $error("FAIL idle_timeout got age %0d exp idle", m_age);
      end
   endtask

   task automatic clear_log();
      for (int i = 0; i < 256; i++) tk_log[i] = 'x;
   endtask

   initial begin
      step(1'b0, 1'b1, 1'b1, r128(), r64());
      step(1'b0, 1'b1, 1'b1, r128(), r64());
      chk1("rst_ready", 64'(in_ready), 64'h1);

      // timing + Q check; in_valid held high throughout, key/tweak churn during the job
      clear_log();
      o_ld = '0; o_re = '0; o_lr = '0; o_ov = '0; o_ir = '0;
      rec_off = 1;
      step(1'b1, 1'b1, 1'b0, 128'h0, 64'h0123456789ABCDEF);
      for (int i = 0; i < 34; i++) step(1'b1, 1'b1, 1'b0, r128(), r64());
      rec_off = -1;
      e_ld = '0; e_re = '0; e_lr = '0; e_ov = '0; e_ir = '0;
      e_ld[1] = 1'b1; e_lr[33] = 1'b1; e_ov[34] = 1'b1; e_ir[35] = 1'b1;
      for (int i = 2; i <= 33; i++) e_re[i] = 1'b1;
      chk1("tm_load",       64'(o_ld), 64'(e_ld));
      chk1("tm_round_en",   64'(o_re), 64'(e_re));
      chk1("tm_last_round", 64'(o_lr), 64'(e_lr));
      chk1("tm_out_valid",  64'(o_ov), 64'(e_ov));
      chk1("tm_in_ready",   64'(o_ir), 64'(e_ir));
      chk1("q_rnd0", tk_log[0], 64'h0123456789ABCDEF);
      chk1("q_rnd2", tk_log[2], 64'hCAF5E892B374601D);
      run_to_idle();

      // key-half check
      clear_log();
      step(1'b1, 1'b1, 1'b0, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, 64'h0);
      run_to_idle();
      chk1("kh_rnd0",  tk_log[0],  64'hFFFF_FFFF_FFFF_FFFF);
      chk1("kh_rnd1",  tk_log[1],  64'h0);
      chk1("kh_rnd3",  tk_log[3],  64'h0);
      chk1("kh_rnd4",  tk_log[4],  64'hFFFF_FFFF_FFFF_FFFF);
      chk1("kh_rnd30", tk_log[30], 64'hFFFF_FFFF_FFFF_FFFF);
      chk1("kh_rnd31", tk_log[31], 64'h0);

      // backpressure in DONE with a pending new job
      step(1'b1, 1'b0, 1'b0, r128(), r64());
      for (int i = 0; i < 100 && m_age != N + 2; i++) step(1'b1, 1'b0, 1'b0, r128(), r64());
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 1'b0, r128(), r64());
         chk1("bp_out_valid", 64'(out_valid), 64'h1);
         chk1("bp_in_ready",  64'(in_ready),  64'h0);
      end
      step(1'b1, 1'b1, 1'b0, r128(), r64());
      chk1("bp_idle_ready", 64'(in_ready), 64'h1);
      step(1'b1, 1'b1, 1'b0, r128(), r64());
      chk1("bp_job2_load", 64'(load), 64'h1);
      run_to_idle();

      // mid-run reset at rnd 7
      step(1'b1, 1'b1, 1'b0, r128(), r64());
      for (int i = 0; i < 20 && m_age != 9; i++) step(1'b0, 1'b1, 1'b0, r128(), r64());
      chk1("abort_rnd7", 64'(rnd), 64'd7);
      step(1'b0, 1'b1, 1'b1, r128(), r64());
      chk1("abort_ready",     64'(in_ready),  64'h1);
      chk1("abort_round_en",  64'(round_en),  64'h0);
      chk1("abort_out_valid", 64'(out_valid), 64'h0);
      step(1'b1, 1'b1, 1'b0, r128(), r64());
      step(1'b0, 1'b1, 1'b0, r128(), r64());
      chk1("restart_rnd0", 64'(rnd), 64'd0);
      run_to_idle();

      // random traffic
      for (int i = 0; i < 1500; i++)
         step(1'($urandom % 2), 1'(($urandom % 10) < 6), 1'(($urandom % 100) == 0),
              r128(), r64());

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/craft_round_ctrl.md
CRAFT_ROUND_CTRL -- requirements
Module: craft_round_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter: NUM_ROUNDS, default 32, meaning the number of rounds per block (legal range 1..255).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  the requester offers a new key/tweak job.
REQ-006 in_ready  output  1  the controller accepts a job; this is high only in IDLE.
REQ-007 key  input  128  master key, sampled at acceptance; K0=key[127:64], K1=key[63:0].
REQ-008 tweak  input  64  tweak, sampled at acceptance.
REQ-009 load  output  1  one-cycle pulse telling the datapath to capture its plaintext.
REQ-010 round_en  output  1  the datapath executes one round this cycle.
REQ-011 rnd  output  8  current round index.
REQ-012 tk  output  64  round tweakey for rnd; it is meaningful only when round_en=1.
REQ-013 last_round  output  1  high together with round_en on round NUM_ROUNDS-1.
REQ-014 out_valid  output  1  the job is complete; this is held until accepted.
REQ-015 out_ready  input  1  the consumer accepts the result.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, RUN and DONE, encoded in 2 bits.
REQ-017 IDLE: in_ready=1; when in_valid=1, the block SHALL latch key and tweak into internal registers and go to LOAD.
REQ-018 LOAD: load=1 for exactly one cycle, the round counter is set to 0, and the next state is RUN.
REQ-019 RUN: round_en=1 every cycle; rnd equals the counter; the counter increments by 1 each cycle.
REQ-020 In RUN, at counter=NUM_ROUNDS-1, last_round=1 and the next state is DONE; the counter holds.
REQ-021 DONE: out_valid=1; on out_ready=1 the next state is IDLE; otherwise the block stays in DONE with all outputs stable.
REQ-022 Latency: acceptance at cycle t, load at t+1, rounds at t+2 .. t+1+NUM_ROUNDS, out_valid from t+2+NUM_ROUNDS.
REQ-023 New jobs SHALL NOT be accepted outside IDLE; in_valid there is ignored and key/tweak are not re-sampled.
REQ-024 Nibble numbering: nibble j of a 64-bit word occupies bits [63-4j : 60-4j].
REQ-025 Q(T): output nibble j equals input nibble P[j], where P = 12,10,15,5,14,8,9,2,11,3,7,4,6,0,1,13.
REQ-026 tk selection by rnd mod 4 (using latched K0/K1/T):
  - 0 -> K0^T
  - 1 -> K1^T
  - 2 -> K0^Q(T)
  - 3 -> K1^Q(T)
REQ-027 tk SHALL be combinational from the latched registers and the counter only; it SHALL NOT depend combinationally on the key/tweak inputs.
REQ-028 Outputs not asserted in the current state SHALL be 0; rnd and tk SHALL be 0 outside RUN.
REQ-029 The counter SHALL never exceed NUM_ROUNDS-1, and SHALL NOT wrap within a job.
REQ-030 If out_valid and out_ready are both high in DONE with in_valid also high, acceptance of the new job SHALL occur in the following IDLE cycle, not in the same cycle.

Reset
REQ-031 When rst=1, the next state SHALL be IDLE regardless of the current state, including mid-RUN.
REQ-032 Reset SHALL clear the counter, the latched key and tweak, load, round_en, last_round and out_valid, all to 0.
REQ-033 The cycle after reset SHALL have in_ready=1; an aborted job SHALL produce no out_valid.

Verification
REQ-034 Q check: key=0, tweak=64'h0123456789ABCDEF; required tk values:
  - rnd=0: 64'h0123456789ABCDEF
  - rnd=2: 64'hCAF5E892B374601D
REQ-035 Key half check: key={64'hFFFFFFFFFFFFFFFF,64'h0}, tweak=0; required tk values:
  - rnd 0,4,...: all-ones
  - rnd 1,3,...: 0
  - rnd 30: all-ones
  - rnd 31: 0
REQ-036 Timing: in_valid held at cycle 0, NUM_ROUNDS=32, out_ready=1; required response:
  - load at cycle 1
  - round_en at cycles 2..33
  - last_round only at cycle 33
  - out_valid at cycle 34
  - in_ready at cycle 35
REQ-037 Backpressure: out_ready held low for 10 cycles in DONE -> out_valid remains 1 and in_ready remains 0; job 2 is accepted only after out_ready goes high.
REQ-038 Mid-run reset: rst asserted at rnd=7 -> the next cycle shows IDLE, round_en=0, out_valid=0 and in_ready=1; a subsequent job runs rounds from rnd=0.
REQ-039 Input stability: key and tweak change every cycle during RUN -> tk matches only the values latched at acceptance.
